alsu_cmd_sequencer: RTL
=======================

# alsu_cmd_sequencer

Queues ALSU command words captured from the board switches and issues them one at a time to the registered ALSU datapath. After each issue it waits out the ALSU pipeline latency, captures the result, and holds it for a fixed dwell time so the seven-segment controller and LEDs show each result in turn. Sits between the switch/button front end and the ALSU on the Basys3 top level.

## Interface
- DEPTH, 4 — command queue entries (power of two, ≥2)
- ALSU_LATENCY, 2 — clocks from alsu_cmd change to valid ALSU outputs (≥1)
- DWELL_CYCLES, 100_000_000 — clocks each result is held (≥1)
- clock_100Mhz  in  1  system clock
- reset  in  1  synchronous, active-low reset
- push  in  1  one-cycle pulse; enqueue sw_cmd (debounced and edge-detected upstream)
- sw_cmd  in  16  {A[2:0],B[2:0],op_code[2:0],c_in,s_in,direction,red_op_A,red_op_B,bypass_A,bypass_B}
- run  in  1  level; 1 = issue queued commands, 0 = pause after the current command
- flush  in  1  one-cycle pulse; empty the queue and abort to IDLE
- alsu_cmd  out  16  registered command to the ALSU, same field layout as sw_cmd
- alsu_out  in  6  ALSU result
- alsu_leds  in  16  ALSU leds; nonzero means an invalid op
- result  out  6  captured alsu_out
- result_valid  out  1  high throughout DWELL
- invalid  out  1  captured |alsu_leds
- count  out  $clog2(DEPTH)+1  queue occupancy
- empty, full  out  1  queue status
- overflow  out  1  sticky; push dropped while full; cleared only by reset
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, DWELL.
- IDLE: if run && !empty, pop head into alsu_cmd, load the latency counter with ALSU_LATENCY−1, go to WAIT. Otherwise stay.
- WAIT: decrement the latency counter. At 0, capture result←alsu_out and invalid←|alsu_leds, load the dwell counter with DWELL_CYCLES−1, go to DWELL.
- DWELL: result_valid=1. Decrement the dwell counter. At 0, go to IDLE.
- run is sampled only in IDLE. Dropping run mid-command does not cut that command short.
- Push when not full: write at the tail and increment count.
- Push when full and no pop in the same cycle: drop the push and set overflow.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full as well.
- flush has priority over push, pop and all FSM activity. It sets count=0, moves to IDLE, and clears result_valid. result, invalid and alsu_cmd keep their values.
- alsu_cmd holds the last issued command between commands.

## Timing
- Reset values: alsu_cmd=0, result=0, result_valid=0, invalid=0, count=0, empty=1, full=0, overflow=0, busy=0, state=IDLE.
- Reset is synchronous and active-low. Asserting reset mid-command returns all outputs to reset values on the next edge.
- Start-up latency with an empty queue, run=1 and the FSM in IDLE:
  - push sampled at edge t; entry visible at t+1.
  - alsu_cmd updates at edge t+2.
  - result captured at edge t+2+ALSU_LATENCY.
- result_valid stays high for exactly DWELL_CYCLES clocks.
- Back-to-back commands: the next alsu_cmd updates 1 clock after DWELL exits.
- Per-command period is 1+ALSU_LATENCY+DWELL_CYCLES clocks.
- Pointers wrap modulo DEPTH.

## Configuration
- ALSU_SEQ_LOOP_EN defined:
  - Issuing does not remove the entry. A play index walks head..head+count−1 and wraps to 0, so the queue replays forever while run=1.
  - count and empty change only on push or flush.
  - Push is still allowed until full.
- ALSU_SEQ_LOOP_EN undefined: issue pops the entry (plain FIFO), as described above.

## Structure
- Package alsu_seq_pkg holds:
  - CMD_W=16 and the field bit offsets and widths of the command word.
  - The FSM state enum {IDLE, WAIT, DWELL}.
- Sub-module alsu_cmd_fifo contains the storage, pointers, count, full/empty and overflow. It takes a peek-index input for loop mode.
- The FSM, counters and result capture stay in alsu_cmd_sequencer.

## Test plan
Bench settings: DEPTH=4, ALSU_LATENCY=2, DWELL_CYCLES=4, with a registered 2-stage ALSU model.
- Single command: run=1, push {A=111,B=110,op=011, all other flags 0} → alsu_cmd equals that word 2 clocks after push; result=6'b101010 and invalid=0 after 2 more clocks; result_valid high for 4 clocks; busy then falls.
- Ordering and back-to-back: with run=0, push AND (A=111,B=110,op=000), then op=110 → issue order AND then invalid. First result=6'b000110, invalid=0. Second: invalid=1, result=0. Command period is 7 clocks.
- Full/overflow: with run=0, push 5 commands → count=4, full=1, overflow=1; the 5th command is never issued.
- Simultaneous push and pop with full=1 and run=1 → count stays 4 and overflow stays 0.
- flush during DWELL → next clock: state IDLE, count=0, result_valid=0, result unchanged. reset=0 mid-WAIT → all outputs at reset values.
- With ALSU_SEQ_LOOP_EN: push 2 commands, run=1 → commands issue A,B,A,B…; count stays 2 and empty stays 0.

Source files
------------

// File: rtl/alsu_seq_pkg.sv
// alsu_seq_pkg: command word layout and sequencer state encoding shared by the ALSU command sequencer files
package alsu_seq_pkg;
  localparam int CMD_W = 16;
  localparam int A_LSB = 13;
  localparam int A_W = 3;
  localparam int B_LSB = 10;
  localparam int B_W = 3;
  localparam int OP_LSB = 7;
  localparam int OP_W = 3;
  localparam int CIN_BIT = 6;
  localparam int SIN_BIT = 5;
  localparam int DIR_BIT = 4;
  localparam int RED_A_BIT = 3;
  localparam int RED_B_BIT = 2;
  localparam int BYP_A_BIT = 1;
  localparam int BYP_B_BIT = 0;
  typedef logic [CMD_W-1:0] cmd_t;
  typedef enum logic [1:0] {IDLE, WAIT, DWELL} seq_state_t;
endpackage

// File: rtl/alsu_cmd_sequencer_if.sv
// alsu_cmd_sequencer_if: switch front end, ALSU and display-side signals of the command sequencer
interface alsu_cmd_sequencer_if import alsu_seq_pkg::*; #(parameter int DEPTH = 4) ();
  logic push;
  cmd_t sw_cmd;
  logic run;
  logic flush;
  cmd_t alsu_cmd;
  logic [5:0] alsu_out;
  logic [15:0] alsu_leds;
  logic [5:0] result;
  logic result_valid;
  logic invalid;
  logic [$clog2(DEPTH):0] count;
  logic empty;
  logic full;
  logic overflow;
  logic busy;
  modport slave (
    input push, sw_cmd, run, flush, alsu_out, alsu_leds,
    output alsu_cmd, result, result_valid, invalid, count, empty, full, overflow, busy
  );
  modport master (
    output push, sw_cmd, run, flush, alsu_out, alsu_leds,
    input alsu_cmd, result, result_valid, invalid, count, empty, full, overflow, busy
  );
endinterface

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: command queue with head-relative peek, occupancy, full/empty and sticky overflow
module alsu_cmd_fifo import alsu_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input logic clock_100Mhz,
  input logic reset,
  input logic push,
  input logic pop,
  input logic flush,
  input cmd_t din,
  input logic [$clog2(DEPTH)-1:0] peek,
  output cmd_t dout,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full,
  output logic overflow
);
  localparam int PW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic rd, wr;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign rd = pop && !empty && !flush;
  assign wr = push && (!full || rd) && !flush;
  assign dout = mem[rd_ptr + peek];
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= flush ? '0 : rd ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr <= flush ? '0 : wr ? wr_ptr + PW'(1) : wr_ptr;
      count <= flush ? '0 : count + (PW+1)'(wr) - (PW+1)'(rd);
      overflow <= overflow || (push && full && !rd && !flush);
    end
  end
  always_ff @(posedge clock_100Mhz) begin
    if (wr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer: issues queued ALSU commands one at a time, waits out the ALSU latency and holds each result for a dwell period (define ALSU_SEQ_LOOP_EN for endless replay)
module alsu_cmd_sequencer import alsu_seq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ALSU_LATENCY = 2,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input logic clock_100Mhz,
  input logic reset,
  alsu_cmd_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNT_W = $clog2((DWELL_CYCLES > ALSU_LATENCY ? DWELL_CYCLES : ALSU_LATENCY) + 1);
  seq_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic issue, capture, avail, pop;
  logic [PW-1:0] peek;
  cmd_t head;
  alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_100Mhz,
    .reset,
    .push(bus.push),
    .pop,
    .flush(bus.flush),
    .din(bus.sw_cmd),
    .peek,
    .dout(head),
    .count(bus.count),
    .empty(bus.empty),
    .full(bus.full),
    .overflow(bus.overflow)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    issue = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        issue = bus.run && avail;
        state_n = issue ? WAIT : IDLE;
        cnt_n = issue ? CNT_W'(ALSU_LATENCY - 1) : cnt;
      end
      WAIT: begin
        capture = cnt == '0;
        state_n = capture ? DWELL : WAIT;
        cnt_n = capture ? CNT_W'(DWELL_CYCLES - 1) : cnt - CNT_W'(1);
      end
      DWELL: begin
        state_n = cnt == '0 ? IDLE : DWELL;
        cnt_n = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
    if (bus.flush) begin
      state_n = IDLE;
      issue = 1'b0;
      capture = 1'b0;
    end
  end
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      avail <= 1'b0;
      bus.alsu_cmd <= '0;
      bus.result <= '0;
      bus.invalid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      avail <= !bus.empty && !bus.flush;
      if (issue) bus.alsu_cmd <= head;
      if (capture) bus.result <= bus.alsu_out;
      if (capture) bus.invalid <= |bus.alsu_leds;
    end
  end
  assign bus.result_valid = state == DWELL;
  assign bus.busy = state != IDLE;
`ifdef ALSU_SEQ_LOOP_EN
  logic [PW-1:0] pidx;
  always_ff @(posedge clock_100Mhz) begin
    if (!reset || bus.flush) pidx <= '0;
    else if (issue) pidx <= (PW+1)'(pidx) + (PW+1)'(1) >= bus.count ? '0 : pidx + PW'(1);
  end
  assign pop = 1'b0;
  assign peek = pidx;
`else
  assign pop = issue;
  assign peek = '0;
`endif
endmodule
